// File: rtl/cpu_datapath.sv
// cpu_datapath -- 8-bit accumulator CPU datapath driven by an external controller.
//   Holds PC, IR, OPR (operand byte), DR, ACC/carry and a small register file,
//   and generates the shared ROM/RAM address and strobes.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   write_r .. ad_sel controller strobes; fetch = phase code (00/01/10)
//   ins               current opcode IR[7:5]
//   mem_addr          PC (ad_sel=0) or OPR (ad_sel=1)
//   rom_cs, rom_rd    ROM strobes (pass-through); rom_rdata ROM data
//   ram_cs/we/re      RAM strobes; ram_wdata = DR; ram_rdata RAM data
//   acc, carry        accumulator and carry of the last ADD
//   bus_err           sticky illegal-strobe-combination flag
module cpu_datapath #(
   parameter int RBITS = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       write_r,
   input  logic       read_r,
   input  logic       PC_en,
   input  logic       ac_ena,
   input  logic       ram_ena,
   input  logic       rom_ena,
   input  logic       ram_write,
   input  logic       ram_read,
   input  logic       rom_read,
   input  logic       ad_sel,
   input  logic [1:0] fetch,
   output logic [2:0] ins,
   output logic [7:0] mem_addr,
   output logic       rom_cs,
   output logic       rom_rd,
   input  logic [7:0] rom_rdata,
   output logic       ram_cs,
   output logic       ram_we,
   output logic       ram_re,
   output logic [7:0] ram_wdata,
   input  logic [7:0] ram_rdata,
   output logic [7:0] acc,
   output logic       carry,
   output logic       bus_err
);

   localparam int NREG = 1 << RBITS;

   localparam logic [2:0] OP_LDO = 3'b001;
   localparam logic [2:0] OP_LDA = 3'b010;
   localparam logic [2:0] OP_STO = 3'b011;
   localparam logic [2:0] OP_PRE = 3'b100;
   localparam logic [2:0] OP_ADD = 3'b101;

   logic [7:0] pc, ir, opr, dr, acc_q;
   logic       carry_q, expect_op, err_q;
   logic [7:0] regs [NREG];

   logic             fetch_cyc, is_long, illegal;
   logic [RBITS-1:0] ridx;

   assign ridx      = ir[RBITS-1:0];
   assign fetch_cyc = rom_ena & rom_read & ~ad_sel;
   // Opcode of the byte currently on the ROM bus decides whether an operand follows.
   assign is_long   = (rom_rdata[7:5] == OP_LDO) || (rom_rdata[7:5] == OP_LDA) ||
                      (rom_rdata[7:5] == OP_STO);
   assign illegal   = (ram_write & ram_read) | (rom_ena & ram_ena) | (write_r & read_r);

   assign ins       = ir[7:5];
   assign mem_addr  = ad_sel ? opr : pc;
   assign rom_cs    = rom_ena;
   assign rom_rd    = rom_read;
   assign ram_cs    = ram_ena;
   assign ram_we    = ram_ena & ram_write & (fetch == 2'b10);
   // Write wins over read on a conflicting request.
   assign ram_re    = ram_ena & ram_read & ~ram_write;
   assign ram_wdata = dr;
   assign acc       = acc_q;
   assign carry     = carry_q;
   assign bus_err   = err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc        <= '0;
         ir        <= '0;
         opr       <= '0;
         dr        <= '0;
         acc_q     <= '0;
         carry_q   <= 1'b0;
         expect_op <= 1'b0;
         err_q     <= 1'b0;
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         if (PC_en) pc <= pc + 8'd1;

         // First byte of an instruction goes to IR; the second byte of a
         // long instruction goes to OPR.
         if (fetch_cyc) begin
            if (!expect_op) begin
               ir        <= rom_rdata;
               expect_op <= is_long;
            end else begin
               opr       <= rom_rdata;
               expect_op <= 1'b0;
            end
         end

         if (read_r && fetch == 2'b01) dr <= regs[ridx];

         if (ac_ena && fetch == 2'b01 && !write_r) begin
            case (ins)
               OP_PRE: begin
                  acc_q   <= dr;
                  carry_q <= 1'b0;
               end
               OP_ADD: {carry_q, acc_q} <= {1'b0, acc_q} + {1'b0, dr};
               default: ;
            endcase
         end

         // Source priority ACC > ROM > RAM; repeated writes of the same data are harmless.
         if (write_r) begin
            if (ac_ena)        regs[ridx] <= acc_q;
            else if (rom_read) regs[ridx] <= rom_rdata;
            else if (ram_read) regs[ridx] <= ram_rdata;
         end

         if (illegal) err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cpu_datapath.sv
module tb_cpu_datapath;

   logic       clk = 1'b0;
   logic       rst;
   logic       write_r, read_r, PC_en, ac_ena, ram_ena, rom_ena;
   logic       ram_write, ram_read, rom_read, ad_sel;
   logic [1:0] fetch;
   logic [2:0] ins;
   logic [7:0] mem_addr, rom_rdata, ram_wdata, ram_rdata, acc;
   logic       rom_cs, rom_rd, ram_cs, ram_we, ram_re, carry, bus_err;

   int total = 0;
   int fails = 0;

   always #5 clk = ~clk;

   cpu_datapath #(.RBITS(5)) dut (
      .clk(clk), .rst(rst),
      .write_r(write_r), .read_r(read_r), .PC_en(PC_en), .ac_ena(ac_ena),
      .ram_ena(ram_ena), .rom_ena(rom_ena), .ram_write(ram_write),
      .ram_read(ram_read), .rom_read(rom_read), .ad_sel(ad_sel), .fetch(fetch),
      .ins(ins), .mem_addr(mem_addr), .rom_cs(rom_cs), .rom_rd(rom_rd),
      .rom_rdata(rom_rdata), .ram_cs(ram_cs), .ram_we(ram_we), .ram_re(ram_re),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .acc(acc), .carry(carry),
      .bus_err(bus_err)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      write_r = 0; read_r = 0; PC_en = 0; ac_ena = 0; ram_ena = 0; rom_ena = 0;
      ram_write = 0; ram_read = 0; rom_read = 0; ad_sel = 0; fetch = 2'b00;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Instruction/operand fetch from ROM with PC increment.
   task automatic do_fetch(input logic [7:0] b);
      clr();
      rom_ena = 1; rom_read = 1; PC_en = 1; rom_rdata = b;
      tick();
      clr();
   endtask

   // Copy REG[IR index] into DR so it shows on ram_wdata.
   task automatic read_reg();
      clr();
      read_r = 1; fetch = 2'b01;
      tick();
      clr();
   endtask

   task automatic ldo_write(input logic [7:0] d);
      clr();
      write_r = 1; rom_read = 1; ad_sel = 1; rom_rdata = d;
      tick(); tick();
      clr();
   endtask

   task automatic accum();
      clr();
      ac_ena = 1; fetch = 2'b01;
      tick();
      clr();
   endtask

   initial begin
      clr();
      rom_rdata = 8'h00; ram_rdata = 8'h00;
      rst = 0;
      tick(); tick();
      // Reset state
      chk("rst_ins", {5'd0, ins}, 8'h00);
      chk("rst_pc", mem_addr, 8'h00);
      ad_sel = 1; #1;
      chk("rst_opr", mem_addr, 8'h00);
      ad_sel = 0;
      chk("rst_acc", acc, 8'h00);
      chk("rst_carry", {7'd0, carry}, 8'h00);
      chk("rst_err", {7'd0, bus_err}, 8'h00);
      chk("rst_dr", ram_wdata, 8'h00);
      rst = 1;
      tick();

      // LDO r3, [0x40] with ROM data 0x5A
      rom_ena = 1; rom_read = 1; #1;
      chk("rom_cs", {7'd0, rom_cs}, 8'h01);
      chk("rom_rd", {7'd0, rom_rd}, 8'h01);
      do_fetch(8'h23);
      chk("ldo_ins", {5'd0, ins}, 8'h01);
      do_fetch(8'h40);
      ldo_write(8'h5A);
      chk("ldo_ins2", {5'd0, ins}, 8'h01);
      ad_sel = 1; #1;
      chk("ldo_opr", mem_addr, 8'h40);
      ad_sel = 0; #1;
      chk("ldo_pc", mem_addr, 8'h02);
      read_reg();
      chk("ldo_r3", ram_wdata, 8'h5A);

      // STO r3, [0x10]
      do_fetch(8'h63);
      do_fetch(8'h10);
      read_reg();
      ram_ena = 1; ram_write = 1; ad_sel = 1; fetch = 2'b10; #1;
      chk("sto_addr", mem_addr, 8'h10);
      chk("sto_we", {7'd0, ram_we}, 8'h01);
      chk("sto_cs", {7'd0, ram_cs}, 8'h01);
      chk("sto_re", {7'd0, ram_re}, 8'h00);
      chk("sto_wdata", ram_wdata, 8'h5A);
      fetch = 2'b00; #1;
      chk("sto_we_ph", {7'd0, ram_we}, 8'h00);
      clr();
      tick();

      // REG1=F0, REG2=20 via LDO; second operand leaves OPR=0x77
      do_fetch(8'h21); do_fetch(8'h00); ldo_write(8'hF0);
      do_fetch(8'h22); do_fetch(8'h77); ldo_write(8'h20);

      // PRE r1 then ADD r2
      do_fetch(8'h81);
      read_reg();
      accum();
      chk("pre_acc", acc, 8'hF0);
      chk("pre_carry", {7'd0, carry}, 8'h00);
      do_fetch(8'hA2);
      read_reg();
      accum();
      chk("add_acc", acc, 8'h10);
      chk("add_carry", {7'd0, carry}, 8'h01);

      // LDM r4
      do_fetch(8'hC4);
      write_r = 1; ac_ena = 1; fetch = 2'b00;
      tick(); tick();
      clr();
      chk("ldm_acc", acc, 8'h10);
      read_reg();
      chk("ldm_r4", ram_wdata, 8'h10);

      // NOP then ADD-opcode fetch: IR loads, OPR kept
      do_fetch(8'h00);
      chk("nop_ins", {5'd0, ins}, 8'h00);
      do_fetch(8'hA1);
      chk("a1_ins", {5'd0, ins}, 8'h05);
      ad_sel = 1; #1;
      chk("a1_opr", mem_addr, 8'h77);
      ad_sel = 0;
      read_reg();
      chk("a1_idx", ram_wdata, 8'hF0);

      // HLT: no state change with PC_en low
      do_fetch(8'hE0);
      chk("hlt_pc", mem_addr, 8'h0E);
      tick(); tick(); tick();
      chk("hlt_pc2", mem_addr, 8'h0E);
      chk("hlt_acc", acc, 8'h10);

      // PC wrap
      PC_en = 1;
      for (int i = 0; i < 8'hF1; i++) tick();
      PC_en = 0; #1;
      chk("pc_ff", mem_addr, 8'hFF);
      PC_en = 1;
      tick();
      PC_en = 0; #1;
      chk("pc_wrap", mem_addr, 8'h00);

      // Reset mid-instruction: next fetch loads IR, register file cleared
      do_fetch(8'h23);
      rst = 0; #2;
      chk("mid_rst_acc", acc, 8'h00);
      rst = 1;
      tick();
      do_fetch(8'h43);
      chk("mid_ins", {5'd0, ins}, 8'h02);
      ad_sel = 1; #1;
      chk("mid_opr", mem_addr, 8'h00);
      ad_sel = 0;
      read_reg();
      chk("rf_cleared", ram_wdata, 8'h00);

      // LDA: write from RAM data
      do_fetch(8'h31);
      ram_ena = 1; ram_read = 1; ad_sel = 1; #1;
      chk("lda_re", {7'd0, ram_re}, 8'h01);
      write_r = 1; ram_rdata = 8'h9C;
      tick(); tick();
      clr();
      read_reg();
      chk("lda_r3", ram_wdata, 8'h9C);
      chk("no_err", {7'd0, bus_err}, 8'h00);

      // Conflicting RAM strobes
      ram_ena = 1; ram_write = 1; ram_read = 1; fetch = 2'b10; #1;
      chk("err_we", {7'd0, ram_we}, 8'h01);
      chk("err_re", {7'd0, ram_re}, 8'h00);
      chk("err_pre", {7'd0, bus_err}, 8'h00);
      tick();
      clr();
      chk("err_set", {7'd0, bus_err}, 8'h01);
      tick(); tick();
      chk("err_hold", {7'd0, bus_err}, 8'h01);
      rst = 0; #2;
      chk("err_clr", {7'd0, bus_err}, 8'h00);
      rst = 1;
      tick();

      // ROM/RAM both enabled
      rom_ena = 1; ram_ena = 1;
      tick();
      clr();
      chk("err_romram", {7'd0, bus_err}, 8'h01);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule

// File: doc/cpu_datapath.md
CPU_DATAPATH -- requirements
Module: cpu_datapath

Interface
REQ-001 The block SHALL have parameter RBITS, default 5, giving the register-address width taken from IR[RBITS-1:0]; the legal range is 1..5.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  Clock; all state updates on the rising edge.
REQ-004 rst  input  1  Reset; asynchronous, active-low.
REQ-005 write_r, read_r, PC_en, ac_ena, ram_ena, rom_ena, ram_write, ram_read, rom_read, ad_sel  input  1 each  Controller strobes.
REQ-006 fetch  input  2  Controller phase code: 00 idle/reg-write, 01 ROM/REG fetch, 10 drive RAM write data.
REQ-007 ins  output  3  Current opcode, equal to IR[7:5], fed back to the controller.
REQ-008 mem_addr  output  8  Shared ROM/RAM address: PC when ad_sel=0, OPR when ad_sel=1.
REQ-009 rom_cs, rom_rd  output  1 each  rom_ena and rom_read passed through.
REQ-010 rom_rdata  input  8  ROM read data, valid in the same cycle as the address.
REQ-011 ram_cs, ram_we, ram_re  output  1 each  RAM chip select, write strobe and read strobe.
REQ-012 ram_wdata  output  8  RAM write data, equal to DR.
REQ-013 ram_rdata  input  8  RAM read data, valid in the same cycle as the address.
REQ-014 acc  output  8  Accumulator value.
REQ-015 carry  output  1  Carry out of the last ADD.
REQ-016 bus_err  output  1  Sticky flag for illegal strobe combinations.

Function
REQ-017 Opcodes SHALL be: NOP=000, LDO=001, LDA=010, STO=011, PRE=100, ADD=101, LDM=110, HLT=111.
- LDO, LDA and STO are long (two-byte) instructions.
REQ-018 PC (8 bit) SHALL increment by 1 on every cycle where PC_en=1, wrapping 0xFF to 0x00.
REQ-019 A fetch cycle is rom_ena & rom_read & !ad_sel; on a fetch cycle the block SHALL act on the expect_op flag as follows:
- expect_op=0: IR <= rom_rdata, and expect_op <= 1 exactly when rom_rdata[7:5] is a long opcode.
- expect_op=1: OPR <= rom_rdata and expect_op <= 0.
REQ-020 When read_r=1 and fetch=01, DR SHALL be loaded with REG[IR[RBITS-1:0]].
REQ-021 When ac_ena=1, fetch=01 and write_r=0, the accumulator SHALL update as follows:
- ins=PRE: ACC <= DR and carry <= 0.
- ins=ADD: {carry, ACC} <= ACC + DR, with 8-bit wrap.
- any other opcode: no change.
REQ-022 When write_r=1, REG[IR[RBITS-1:0]] SHALL be written with the first matching source in this order:
1. ACC, if ac_ena=1 (LDM).
2. rom_rdata, if rom_read=1 (LDO).
3. ram_rdata, if ram_read=1 (LDA).
- If none matches, no write occurs.
REQ-023 Register writes repeated over consecutive cycles with the same data SHALL be idempotent.
- This covers the two-cycle LDO/LDA/LDM sequences.
REQ-024 The RAM strobes SHALL be driven as follows:
- ram_cs = ram_ena.
- ram_we = ram_ena & ram_write & (fetch==10).
- ram_re = ram_ena & ram_read & !ram_write.
REQ-025 bus_err SHALL set one cycle after any of these combinations and stay set until reset:
- ram_write & ram_read.
- rom_ena & ram_ena.
- write_r & read_r.
REQ-026 On simultaneous ram_write and ram_read, the write SHALL win and ram_re SHALL be 0.
REQ-027 HLT SHALL change no state; PC holds while PC_en is low.
REQ-028 All registered outputs SHALL change only on the rising clk edge; mem_addr, the ROM/RAM strobes and ins are combinational from registers and inputs.

Reset
REQ-029 While rst=0, the block SHALL hold the following values:
- PC, IR, OPR, DR, ACC and expect_op = 0; carry and bus_err = 0.
- The outputs then read ins=000 and mem_addr=0x00.
REQ-030 The register file SHALL be cleared to 0 by reset.
REQ-031 Reset asserted mid-instruction SHALL abort the instruction; the first fetch after release loads IR, never OPR.

Verification
REQ-032 LDO: reset, then fetch with rom_rdata=0x23, PC_en, fetch with 0x40, two write_r+rom_read+ad_sel cycles with rom_rdata=0x5A -> ins=001, OPR=0x40, mem_addr=0x40, REG[3]=0x5A, PC=0x02.
REQ-033 STO: IR=0x63, OPR=0x10, REG[3]=0x5A; read_r+fetch=01, then ram_ena+ram_write+ad_sel+fetch=10 -> mem_addr=0x10, ram_we=1, ram_wdata=0x5A.
REQ-034 PRE/ADD: REG[1]=0xF0, REG[2]=0x20; PRE r1 then ADD r2 sequences -> ACC=0xF0 after PRE, then ACC=0x10 and carry=1 after ADD.
REQ-035 LDM: IR=0xC4, ACC=0x10; two write_r+ac_ena cycles with fetch=00 -> REG[4]=0x10, ACC unchanged.
REQ-036 Boundary: PC=0xFF with PC_en -> PC=0x00; NOP (0x00) fetch followed by a fetch of 0xA1 -> IR=0xA1, OPR unchanged.
REQ-037 Errors: ram_ena+ram_write+ram_read with fetch=10 -> ram_we=1, ram_re=0, bus_err=1 next cycle and held until rst=0.
